conv_interleaver_param: RTL and testbench

//  Parametrised convolutional (Forney) interleaver/deinterleaver with one symbol in and one symbol out per enable.
//  A commutator steps through BRANCHES FIFO delay branches; branch b delays its symbols by D(b) visits.

---
 rtl/conv_il_pkg.sv | 26 ++
 rtl/conv_branch_delay.sv | 40 ++++
 rtl/conv_interleaver_param.sv | 94 +++++++++
 tb/tb_conv_interleaver_param.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_il_pkg.sv
// Shared helpers for the convolutional interleaver: branch depth law, index width
// and fill length of the commutator.
package conv_il_pkg;

  localparam int DEF_BRANCHES   = 12;
  localparam int DEF_UNIT_DEPTH = 17;

  // Minimum 1 bit so that a 1-entry buffer or 2-branch commutator still gets a pointer.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int branch_depth(input int b, input int i, input int m, input bit mode);
    return mode ? (i - 1 - b) * m : b * m;
  endfunction

  function automatic int fill_len(input int i, input int m);
    return (i - 1) * m * i;
  endfunction

  localparam int FILL_LEN = fill_len(DEF_BRANCHES, DEF_UNIT_DEPTH);

endpackage

// File: rtl/conv_branch_delay.sv
// One commutator branch: circular buffer of DEPTH symbols, read-before-write at the
// write pointer, so dout is always the entry written DEPTH visits ago.
module conv_branch_delay #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  import conv_il_pkg::*;

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, en};
      assign dout = din;
    end else begin : g_buf
      localparam int PTR_W = clog2(DEPTH);

      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr;

      assign dout = mem[wr_ptr];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr <= '0;
          for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (en) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/conv_interleaver_param.sv
// Forney convolutional interleaver/deinterleaver: commutator over BRANCHES delay lines,
// registered output mux and a saturating fill counter.
module conv_interleaver_param
  import conv_il_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int BRANCHES     = 12,
  parameter int UNIT_DEPTH   = 17,
  parameter int DEINTERLEAVE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          buf_en,
  input  logic                          sync_in,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  output logic [clog2(BRANCHES)-1:0]    branch_idx,
  output logic                          fill_done
);

  localparam int IDX_W    = clog2(BRANCHES);
  localparam int FILL_N   = fill_len(BRANCHES, UNIT_DEPTH);
  localparam int FILL_W   = clog2(FILL_N + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_N);
  localparam bit   MODE     = (DEINTERLEAVE != 0);

  logic [IDX_W-1:0]  cmt;
  logic [IDX_W-1:0]  sel_p0;
  logic [BRANCHES-1:0] branch_en_p0;
  logic [DATA_W-1:0] branch_out_p0 [BRANCHES];
  logic [FILL_W-1:0] fill_cnt;

  // Stage p0: commutator select, branch access (combinational read of the oldest entry)
  assign sel_p0 = sync_in ? '0 : cmt;

  always_comb begin
    branch_en_p0         = '0;
    branch_en_p0[sel_p0] = buf_en;
  end

  for (genvar b = 0; b < BRANCHES; b++) begin : g_branch
    conv_branch_delay #(
      .DATA_W (DATA_W),
      .DEPTH  (branch_depth(b, BRANCHES, UNIT_DEPTH, MODE))
    ) u_delay (
      .clk   (clk),
      .reset (reset),
      .en    (branch_en_p0[b]),
      .din   (data_in),
      .dout  (branch_out_p0[b])
    );
  end

  // A sync strobe without a symbol only re-arms the commutator for the next symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmt <= '0;
    end else if (buf_en) begin
      cmt <= (sel_p0 == IDX_W'(BRANCHES - 1)) ? '0 : sel_p0 + 1'b1;
    end else if (sync_in) begin
      cmt <= '0;
    end
  end

  // Stage p1: registered output; data and branch hold between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      branch_idx <= '0;
    end else begin
      valid_out <= buf_en;
      if (buf_en) begin
        data_out   <= branch_out_p0[sel_p0];
        branch_idx <= sel_p0;
      end
    end
  end

  // Sync restarts the fill count but leaves branch contents intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if (sync_in) begin
      fill_cnt <= '0;
    end else if (buf_en && (fill_cnt != FILL_MAX)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  assign fill_done = (fill_cnt == FILL_MAX);

endmodule

// File: tb/tb_conv_interleaver_param.sv
// Scoreboard bench: interleaver (I=12,M=17) chained into a deinterleaver, plus a
// small I=2,M=1,DATA_W=1 instance for the corner parameters.
module tb_conv_interleaver_param;

  localparam int I    = 12;
  localparam int M    = 17;
  localparam int LAT  = (I - 1) * M * I;
  localparam int LB_N = 10000 + LAT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       buf_en = 1'b0, sync_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] branch_idx;
  logic       fill_done;

  logic       dl_sync = 1'b0;
  logic [7:0] dl_out;
  logic       dl_valid;
  logic [3:0] dl_idx_unused;
  logic       dl_fill;

  logic       en2 = 1'b0, sync2 = 1'b0;
  logic [0:0] d2 = 1'b0;
  logic [0:0] q2;
  logic       v2;
  logic [0:0] idx2;
  logic       fill2_unused;

  conv_interleaver_param #(.DATA_W(8), .BRANCHES(I), .UNIT_DEPTH(M), .DEINTERLEAVE(0)) dut (
    .clk(clk), .reset(reset), .buf_en(buf_en), .sync_in(sync_in), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .branch_idx(branch_idx), .fill_done(fill_done));

  conv_interleaver_param #(.DATA_W(8), .BRANCHES(I), .UNIT_DEPTH(M), .DEINTERLEAVE(1)) deint (
    .clk(clk), .reset(reset), .buf_en(valid_out), .sync_in(dl_sync), .data_in(data_out),
    .data_out(dl_out), .valid_out(dl_valid), .branch_idx(dl_idx_unused), .fill_done(dl_fill));

  conv_interleaver_param #(.DATA_W(1), .BRANCHES(2), .UNIT_DEPTH(1), .DEINTERLEAVE(0)) dut2 (
    .clk(clk), .reset(reset), .buf_en(en2), .sync_in(sync2), .data_in(d2),
    .data_out(q2), .valid_out(v2), .branch_idx(idx2), .fill_done(fill2_unused));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural model: each branch is a queue; a visit pushes the new symbol and
  // yields the one pushed D(b) visits earlier, or 0 while the branch is filling.
  typedef struct packed { logic [7:0] data; logic [3:0] idx; } exp_t;
  exp_t       sbq [$];
  logic [7:0] hist [I][$];
  int         cmt_m = 0;

  task automatic model_reset();
    sbq.delete();
    for (int b = 0; b < I; b++) hist[b].delete();
    cmt_m = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic en);
    exp_t e;
    int   sel;
    data_in = d;
    sync_in = s;
    buf_en  = en;
    if (en) begin
      sel = s ? 0 : cmt_m;
      hist[sel].push_back(d);
      e.idx  = sel[3:0];
      e.data = (hist[sel].size() > sel * M) ? hist[sel].pop_front() : 8'h00;
      sbq.push_back(e);
      cmt_m = (sel + 1) % I;
    end else if (s) begin
      cmt_m = 0;
    end
    @(posedge clk); #1;
    buf_en  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Main monitor: valid_out must follow buf_en by one clock; payload comes off the scoreboard.
  logic en_q = 1'b0;
  initial forever begin @(posedge clk); en_q = buf_en; end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      check("valid", valid_out, en_q);
      if (valid_out) begin
        check("sb_pop", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("data", data_out, e.data);
          check("bidx", branch_idx, e.idx);
        end
      end
    end
  end

  // Loopback monitor: deinterleaver output n must be input n-LAT (zero before that).
  logic [7:0] lb_in [LB_N];
  int lb_n = 0;
  bit lb_on = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!reset && lb_on && dl_valid) begin
      check("loop", dl_out, (lb_n >= LAT) ? lb_in[lb_n - LAT] : 8'h00);
      lb_n++;
    end
  end

  // Small instance: I=2, M=1 -> branch 1 delays by one visit = 2 symbols.
  logic in2 [64];
  int   n2_tx = 0, n2_rx = 0;
  initial forever begin
    int b, k;
    @(negedge clk);
    if (!reset && v2) begin
      b = n2_rx % 2;
      k = n2_rx - b * 2;
      check("s_data", q2, (k >= 0) ? in2[k] : 1'b0);
      check("s_idx", idx2, b);
      n2_rx++;
    end
  end

  task automatic send2(input logic bitv);
    d2 = bitv;
    in2[n2_tx] = bitv;
    n2_tx++;
    en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    logic [7:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_idx", branch_idx, 0);
    check("rst_fill", fill_done, 0);
    check("rst_s_valid", v2, 0);

    // Continuous ramp
    for (int n = 0; n < 300; n++) begin
      send(8'(n), 1'b0, 1'b1);
      if (n == 12)  check("ramp_echo12", data_out, 12);
      if (n == 217) check("ramp217", data_out, 13);
    end
    idle(3);
    check("ramp_drain", sbq.size(), 0);

    // Reset in the middle of a stream
    pulse_reset();
    send(8'h55, 1'b0, 1'b1);
    check("pre_rst_data", data_out, 8'h55);
    buf_en  = 1'b1;
    data_in = 8'h66;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", data_out, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_idx", branch_idx, 0);
    buf_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    send(8'hAB, 1'b0, 1'b1);
    check("post_rst_data", data_out, 8'hAB);
    check("post_rst_idx", branch_idx, 0);
    idle(3);

    // Gapped strobe at ~40% duty, same ramp by symbol index
    pulse_reset();
    sent = 0;
    while (sent < 300) begin
      if ($urandom_range(0, 99) < 40) begin
        send(8'(sent), 1'b0, 1'b1);
        if (sent == 217) check("gap217", data_out, 13);
        sent++;
      end else begin
        send(8'hEE, 1'b0, 1'b0);
      end
    end
    idle(3);
    check("gap_drain", sbq.size(), 0);

    // Interleaver -> deinterleaver loopback
    pulse_reset();
    lb_n  = 0;
    lb_on = 1'b1;
    for (int n = 0; n < LB_N; n++) begin
      d = 8'($urandom);
      lb_in[n] = d;
      send(d, 1'b0, 1'b1);
    end
    idle(4);
    lb_on = 1'b0;
    check("lb_count", lb_n, LB_N);
    check("fill_set", fill_done, 1);
    check("dl_fill_set", dl_fill, 1);

    // Frame sync: clears fill, forces branch 0, refills after LAT further symbols
    for (int n = 0; n < 5; n++) send(8'(n + 3), 1'b0, 1'b1);
    check("fill_held", fill_done, 1);
    send(8'h05, 1'b1, 1'b1);
    check("sync_idx0", branch_idx, 0);
    check("sync_fill_clr", fill_done, 0);
    send(8'h06, 1'b0, 1'b1);
    check("sync_idx1", branch_idx, 1);
    for (int n = 0; n < LAT - 2; n++) send(8'($urandom), 1'b0, 1'b1);
    check("fill_pre", fill_done, 0);
    send(8'h11, 1'b0, 1'b1);
    check("fill_rise", fill_done, 1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b0);
    check("sync_idle_fill", fill_done, 0);
    send(8'h33, 1'b0, 1'b1);
    check("sync_idle_idx", branch_idx, 0);
    idle(3);
    check("sync_drain", sbq.size(), 0);

    // Corner parameters I=2, M=1, DATA_W=1
    pulse_reset();
    for (int n = 0; n < 40; n++) send2(1'($urandom));
    idle(3);
    check("s_count", n2_rx, n2_tx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
